// File: rtl/aer_lane_arbiter_fifo.sv
// Round-robin arbiter over the 10 layer-1 encoder lanes feeding a FIFO-buffered serial AER stream.
// Define AER_ARB_EVENT_CNT_EN to compile in the per-frame event counter (otherwise event_cnt_o = 0).
module aer_lane_arbiter_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int AW         = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic [10*AW-1:0] aer_i,
    input  logic [9:0]       valid_i,
    output logic [9:0]       ack_o,
    output logic [AW-1:0]    aer_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic [9:0]       event_cnt_o
);
    localparam int NUM_LANES = 10;
    localparam int PW        = $clog2(FIFO_DEPTH);
    localparam int CW        = PW + 1;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
    state_t state_q, state_d;

    logic [NUM_LANES-1:0][AW-1:0] lane_aer;
    logic [AW-1:0]                mem [FIFO_DEPTH];
    logic [PW-1:0]                wr_ptr, rd_ptr;
    logic [CW-1:0]                count;
    logic [3:0]                   rr_ptr, grant_idx;
    logic [4:0]                   scan_idx;
    logic                         grant_vld, full, push, pop;

    assign lane_aer     = aer_i;
    assign full         = (count == CW'(FIFO_DEPTH));
    assign valid_o      = (count != '0);
    assign aer_o        = valid_o ? mem[rd_ptr] : '0;
    assign pop          = valid_o && ready_i && !start_i;
    assign push         = grant_vld && (state_q == RUN) && !full && !start_i;
    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = (state_q == DONE);

    // Rotating-priority scan: lane rr_ptr first, wrapping modulo 10; first hit wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            scan_idx = 5'(rr_ptr) + 5'(i);
            if (scan_idx >= 5'(NUM_LANES)) scan_idx = scan_idx - 5'(NUM_LANES);
            if (!grant_vld && valid_i[scan_idx[3:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx[3:0];
            end
        end
    end

    always_comb begin
        ack_o = '0;
        if (push) ack_o[grant_idx] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = IDLE;
            LOAD:    state_d = RUN;
            RUN:     if (valid_i == '0) state_d = DRAIN;
            DRAIN:   if (!valid_o) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (start_i) state_d = LOAD;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // start_i flushes the FIFO outright; a coincident pop is discarded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_ptr <= '0;
        end else if (start_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (grant_idx == 4'(NUM_LANES - 1)) ? 4'd0 : grant_idx + 4'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= lane_aer[grant_idx];
    end

`ifdef AER_ARB_EVENT_CNT_EN
    logic [9:0] event_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                           event_cnt <= '0;
        else if (start_i)                       event_cnt <= '0;
        else if (push && event_cnt != 10'h3FF)  event_cnt <= event_cnt + 10'd1;
    end

    assign event_cnt_o = event_cnt;
`else
    assign event_cnt_o = '0;
`endif

endmodule
